// File: rtl/mem_pkg.sv
// Shared definitions for the memory copy/fill engine.
//   state_t   : engine FSM states
//   ADDR_W    : default memory address width
//   DATA_W    : default memory data width
//   LEN_W     : default transfer length field width
//   MODE_*    : encodings of the mode input
package mem_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 8;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Block-transfer memory master. Copies `length` bytes from src_addr to
// dst_addr (copy mode) or writes fill_value to `length` bytes at dst_addr
// (fill mode), one byte per memory access, strictly in ascending order.
// Keeps an 8-bit running sum of every byte written.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, mode                one-cycle request (IDLE only), 0=copy 1=fill
//   src_addr, dst_addr         transfer base addresses (wrap mod 2^ADDR_W)
//   length, fill_value         byte count and fill byte
//   busy, done                 transfer in progress / one-cycle completion
//   checksum                   sum of bytes written by the last transfer
//   mem_read, mem_write        memory strobes (write lands on posedge)
//   mem_addr, mem_write_data   memory address / write data
//   mem_read_data              combinational read data
module mem_copy_engine #(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W,
    parameter int LEN_W  = mem_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    import mem_pkg::*;

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [DATA_W-1:0] csum_q, csum_d;

    logic [LEN_W-1:0]  cnt_inc;
    logic [DATA_W-1:0] wdata;
    logic              rd_en, wr_en;

    assign cnt_inc = cnt_q + 1'b1;
    assign wdata   = (mode_q == MODE_FILL) ? fill_q : buf_q;

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        src_d          = src_q;
        dst_d          = dst_q;
        len_d          = len_q;
        cnt_d          = cnt_q;
        fill_d         = fill_q;
        buf_d          = buf_q;
        csum_d         = csum_q;
        busy           = 1'b0;
        done           = 1'b0;
        rd_en          = 1'b0;
        wr_en          = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d = mode;
                    src_d  = src_addr;
                    dst_d  = dst_addr;
                    len_d  = length;
                    fill_d = fill_value;
                    cnt_d  = '0;
                    csum_d = '0;
                    if (length == '0)
                        state_d = DONE;
                    else if (mode == MODE_FILL)
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ: begin
                busy     = 1'b1;
                rd_en    = 1'b1;
                mem_addr = src_q + ADDR_W'(cnt_q);
                buf_d    = mem_read_data;
                state_d  = WRITE;
            end
            WRITE: begin
                busy           = 1'b1;
                wr_en          = 1'b1;
                mem_addr       = dst_q + ADDR_W'(cnt_q);
                mem_write_data = wdata;
                csum_d         = csum_q + wdata;
                cnt_d          = cnt_inc;
                if (cnt_inc == len_q)
                    state_d = DONE;
                else if (mode_q == MODE_FILL)
                    state_d = WRITE;
                else
                    state_d = READ;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are gated by reset directly so the edge that samples reset can
    // never commit a write, even when reset arrives mid-transfer.
    assign mem_read  = rd_en & ~reset;
    assign mem_write = wr_en & ~reset;
    assign checksum  = csum_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            fill_q  <= '0;
            buf_q   <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            buf_q   <= buf_d;
            csum_q  <= csum_d;
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
module tb_mem_copy_engine;

    logic       clk;
    logic       reset;
    logic       start;
    logic       mode;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [7:0] length;
    logic [7:0] fill_value;
    logic       busy;
    logic       done;
    logic [7:0] checksum;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] mem_addr;
    logic [7:0] mem_write_data;
    logic [7:0] mem_read_data;

    mem_copy_engine #(.ADDR_W(8), .DATA_W(8), .LEN_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .fill_value(fill_value), .busy(busy), .done(done), .checksum(checksum),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory with 255 entries (0..254); address 255 does not exist.
    logic [7:0] mem     [0:254];
    logic [7:0] exp_mem [0:254];
    int nrd, nwr, nbusy, ndone;
    logic [7:0] waddr_q[$];

    assign mem_read_data = (mem_addr == 8'hFF) ? 8'h00 : mem[mem_addr];

    always @(posedge clk) begin
        if (mem_write && mem_addr != 8'hFF) mem[mem_addr] <= mem_write_data;
        if (mem_read) nrd++;
        if (mem_write) begin
            nwr++;
            waddr_q.push_back(mem_addr);
        end
        if (busy) nbusy++;
        if (done) ndone++;
    end

    // Reference: process bytes in ascending order against the expected image;
    // returns the sum of bytes written (dropped writes still count).
    function automatic logic [7:0] model(input logic m, input logic [7:0] s,
                                         input logic [7:0] d, input logic [7:0] l,
                                         input logic [7:0] f);
        logic [7:0] sum = 8'h00;
        logic [7:0] a, w, v;
        for (int i = 0; i < int'(l); i++) begin
            a = s + 8'(i);
            w = d + 8'(i);
            v = m ? f : ((a == 8'hFF) ? 8'h00 : exp_mem[a]);
            if (w != 8'hFF) exp_mem[w] = v;
            sum = sum + v;
        end
        return sum;
    endfunction

    function automatic int mem_diffs();
        int n = 0;
        for (int i = 0; i < 255; i++) if (mem[i] !== exp_mem[i]) n++;
        return n;
    endfunction

    task automatic poke(input int a, input logic [7:0] v);
        mem[a] = v;
        exp_mem[a] = v;
    endtask

    task automatic clear_mon();
        nrd = 0; nwr = 0; nbusy = 0; ndone = 0;
        waddr_q.delete();
    endtask

    // Issue one request and wait for done; lat = posedges from start to done.
    task automatic run_xfer(input logic m, input logic [7:0] s, input logic [7:0] d,
                            input logic [7:0] l, input logic [7:0] f, output int lat);
        @(negedge clk);
        mode = m; src_addr = s; dst_addr = d; length = l; fill_value = f;
        start = 1'b1;
        clear_mon();
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 600) begin
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) begin
            checks++; errors++;
            $display("FAIL timeout waiting for done: got none within %0d cycles", lat);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; mode = 1'b0;
        src_addr = 8'h0; dst_addr = 8'h0; length = 8'h0; fill_value = 8'h0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, mem_read, mem_write} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got busy/done/rd/wr=%b required 0000", {busy, done, mem_read, mem_write});
        end
        checks++;
        if (checksum !== 8'h00 || mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset_vals: got checksum=%h addr=%h required 00 00", checksum, mem_addr);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_copy_basic();
        int lat;
        logic [7:0] ec;
        for (int i = 0; i < 4; i++) poke(10 + i, 8'(i + 1));
        ec = model(1'b0, 8'd10, 8'd50, 8'd4, 8'h00);
        run_xfer(1'b0, 8'd10, 8'd50, 8'd4, 8'h00, lat);
        checks++;
        if (lat != 9) begin errors++; $display("FAIL copy_latency: got %0d required 9", lat); end
        checks++;
        if (checksum !== 8'd10 || ec !== 8'd10) begin errors++; $display("FAIL copy_checksum: got %0d required 10", checksum); end
        checks++;
        if (nbusy != 8) begin errors++; $display("FAIL copy_busy_cycles: got %0d required 8", nbusy); end
        checks++;
        if (nrd != 4 || nwr != 4) begin errors++; $display("FAIL copy_accesses: got rd=%0d wr=%0d required 4 4", nrd, nwr); end
        checks++;
        if (mem[53] !== 8'd4 || mem_diffs() != 0) begin errors++; $display("FAIL copy_memory: got %0d bad bytes, M[53]=%0d required 0, 4", mem_diffs(), mem[53]); end
    endtask

    task automatic test_fill_basic();
        int lat;
        logic [7:0] ec;
        ec = model(1'b1, 8'd0, 8'd100, 8'd3, 8'hAA);
        run_xfer(1'b1, 8'd0, 8'd100, 8'd3, 8'hAA, lat);
        checks++;
        if (lat != 4) begin errors++; $display("FAIL fill_latency: got %0d required 4", lat); end
        checks++;
        if (checksum !== 8'hFE || ec !== 8'hFE) begin errors++; $display("FAIL fill_checksum: got %h required fe", checksum); end
        checks++;
        if (nrd != 0 || nwr != 3) begin errors++; $display("FAIL fill_accesses: got rd=%0d wr=%0d required 0 3", nrd, nwr); end
        checks++;
        if (mem[102] !== 8'hAA || mem_diffs() != 0) begin errors++; $display("FAIL fill_memory: got %0d bad bytes required 0", mem_diffs()); end
    endtask

    task automatic test_len0();
        int lat;
        run_xfer(1'b0, 8'd10, 8'd60, 8'd0, 8'h00, lat);
        checks++;
        if (lat != 1) begin errors++; $display("FAIL len0_latency: got %0d required 1", lat); end
        checks++;
        if (nrd != 0 || nwr != 0 || nbusy != 0) begin errors++; $display("FAIL len0_activity: got rd=%0d wr=%0d busy=%0d required 0 0 0", nrd, nwr, nbusy); end
        checks++;
        if (checksum !== 8'h00) begin errors++; $display("FAIL len0_checksum: got %h required 00", checksum); end
        checks++;
        if (mem_diffs() != 0) begin errors++; $display("FAIL len0_memory: got %0d bad bytes required 0", mem_diffs()); end
    endtask

    task automatic test_overlap();
        int lat;
        logic [7:0] ec;
        for (int i = 0; i < 4; i++) poke(20 + i, 8'(5 + i));
        ec = model(1'b0, 8'd20, 8'd21, 8'd3, 8'h00);
        run_xfer(1'b0, 8'd20, 8'd21, 8'd3, 8'h00, lat);
        checks++;
        if (mem[21] !== 8'd5 || mem[22] !== 8'd5 || mem[23] !== 8'd5) begin
            errors++; $display("FAIL overlap_data: got %0d %0d %0d required 5 5 5", mem[21], mem[22], mem[23]);
        end
        checks++;
        if (checksum !== 8'd15 || ec !== 8'd15) begin errors++; $display("FAIL overlap_checksum: got %0d required 15", checksum); end
        checks++;
        if (mem_diffs() != 0) begin errors++; $display("FAIL overlap_memory: got %0d bad bytes required 0", mem_diffs()); end
    endtask

    task automatic test_wrap();
        int lat;
        logic [7:0] ec;
        logic [7:0] m0;
        m0 = mem[0];
        ec = model(1'b1, 8'd0, 8'd253, 8'd3, 8'd7);
        run_xfer(1'b1, 8'd0, 8'd253, 8'd3, 8'd7, lat);
        checks++;
        if (waddr_q.size() != 3 || waddr_q[0] !== 8'd253 || waddr_q[1] !== 8'd254 || waddr_q[2] !== 8'd255) begin
            errors++; $display("FAIL wrap_addr_seq: got %0d writes required 253,254,255", waddr_q.size());
        end
        checks++;
        if (mem[253] !== 8'd7 || mem[254] !== 8'd7 || mem[0] !== m0) begin
            errors++; $display("FAIL wrap_memory: got %0d %0d M0=%0d required 7 7 %0d", mem[253], mem[254], mem[0], m0);
        end
        checks++;
        if (checksum !== 8'd21 || ec !== 8'd21 || mem_diffs() != 0) begin errors++; $display("FAIL wrap_checksum: got %0d required 21", checksum); end
    endtask

    task automatic test_reset_midway();
        int lat;
        logic [7:0] ec;
        for (int i = 0; i < 4; i++) begin
            poke(30 + i, 8'(9 - i));
            poke(60 + i, 8'h55);
        end
        exp_mem[60] = 8'd9;
        @(negedge clk);
        mode = 1'b0; src_addr = 8'd30; dst_addr = 8'd60; length = 8'd4; fill_value = 8'h0;
        start = 1'b1;
        clear_mon();
        @(negedge clk); start = 1'b0;      // READ 0
        repeat (3) @(negedge clk);         // WRITE 0, READ 1, WRITE 1
        checks++;
        if (mem_write !== 1'b1 || mem_addr !== 8'd61) begin
            errors++; $display("FAIL midway_state: got wr=%b addr=%0d required 1 61", mem_write, mem_addr);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_write !== 1'b0 || mem_read !== 1'b0) begin
            errors++; $display("FAIL reset_gates_strobes: got wr=%b rd=%b required 0 0", mem_write, mem_read);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || checksum !== 8'h00 || ndone != 0) begin
            errors++; $display("FAIL abandon_state: got busy=%b csum=%h dones=%0d required 0 00 0", busy, checksum, ndone);
        end
        checks++;
        if (nwr != 1 || mem_diffs() != 0) begin
            errors++; $display("FAIL abandon_memory: got %0d writes %0d bad bytes required 1 0", nwr, mem_diffs());
        end
        ec = model(1'b0, 8'd30, 8'd60, 8'd4, 8'h00);
        run_xfer(1'b0, 8'd30, 8'd60, 8'd4, 8'h00, lat);
        checks++;
        if (lat != 9 || checksum !== ec || ec !== 8'd30 || mem_diffs() != 0) begin
            errors++; $display("FAIL restart: got lat=%0d csum=%0d required 9 30", lat, checksum);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [7:0] ec;
        ec = model(1'b1, 8'd0, 8'd150, 8'd4, 8'h11);
        @(negedge clk);
        mode = 1'b1; src_addr = 8'd0; dst_addr = 8'd150; length = 8'd4; fill_value = 8'h11;
        start = 1'b1;
        clear_mon();
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        mode = 1'b1; dst_addr = 8'd160; length = 8'd2; fill_value = 8'h22; start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
        mode = 1'b1; dst_addr = 8'd170; length = 8'd1; fill_value = 8'h33; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (ndone != 1 || nwr != 4) begin
            errors++; $display("FAIL start_ignored: got dones=%0d writes=%0d required 1 4", ndone, nwr);
        end
        checks++;
        if (checksum !== ec || ec !== 8'h44 || mem_diffs() != 0) begin
            errors++; $display("FAIL start_ignored_result: got csum=%h bad=%0d required 44 0", checksum, mem_diffs());
        end
    endtask

    task automatic test_random();
        int lat, elat, ebusy;
        logic m;
        logic [7:0] s, d, l, f, ec;
        for (int i = 0; i < 255; i++) poke(i, 8'($urandom));
        for (int t = 0; t < 12; t++) begin
            m = 1'($urandom);
            l = 8'($urandom_range(0, 16));
            s = 8'($urandom_range(0, 254 - int'(l)));
            d = 8'($urandom_range(0, 254 - int'(l)));
            f = 8'($urandom);
            ec = model(m, s, d, l, f);
            elat  = (l == 0) ? 1 : (m ? int'(l) + 1 : 2 * int'(l) + 1);
            ebusy = (l == 0) ? 0 : (m ? int'(l) : 2 * int'(l));
            run_xfer(m, s, d, l, f, lat);
            checks++;
            if (lat != elat || nbusy != ebusy) begin
                errors++; $display("FAIL rand%0d_timing: got lat=%0d busy=%0d required %0d %0d", t, lat, nbusy, elat, ebusy);
            end
            checks++;
            if (checksum !== ec) begin errors++; $display("FAIL rand%0d_checksum: got %h required %h", t, checksum, ec); end
            checks++;
            if (nwr != int'(l) || nrd != (m ? 0 : int'(l))) begin
                errors++; $display("FAIL rand%0d_accesses: got rd=%0d wr=%0d len=%0d mode=%b", t, nrd, nwr, l, m);
            end
            checks++;
            if (mem_diffs() != 0) begin errors++; $display("FAIL rand%0d_memory: got %0d bad bytes required 0", t, mem_diffs()); end
        end
    endtask

    initial begin
        clear_mon();
        for (int i = 0; i < 255; i++) begin
            mem[i] = 8'h00;
            exp_mem[i] = 8'h00;
        end
        test_reset();
        test_copy_basic();
        test_fill_basic();
        test_len0();
        test_overlap();
        test_wrap();
        test_reset_midway();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
